// File: rtl/hs_source.sv
// Handshake data source: emits an incrementing data word at LFSR-paced intervals,
// either as a one-way strobe (MODE 0) or as a four-phase req/ack transfer (MODE 1).
module hs_source #(
  parameter int          WIDTH   = 8,
  parameter int          MODE    = 0,
  parameter int          PULSE   = 1,
  parameter int          THRESH  = 49,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          TIMEOUT = 64,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             sync,
  output logic             busy,
  output logic [CNT_W-1:0] sent_count,
  output logic             timeout_err
);

  localparam int PW = (PULSE > 1) ? $clog2(PULSE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PULSE - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_REQ, S_REL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             hit;

  // THRESH of 0 means "always launch"; kept out of the comparator so it folds cleanly
  generate
    if (THRESH <= 0) begin : g_always
      assign hit = 1'b1;
    end else begin : g_cmp
      localparam logic [6:0] TH = 7'(THRESH);
      assign hit = ({1'b0, lfsr_q[5:0]} >= TH);
    end
  endgenerate

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    wait_d  = wait_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      S_IDLE: begin
        pcnt_d = '0;
        wait_d = '0;
        if (enable && hit) state_d = (MODE == 0) ? S_SEND : S_REQ;
      end
      S_SEND: begin
        if (pcnt_q == PLAST) begin
          pcnt_d  = '0;
          d_d     = d_q + WIDTH'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_GAP;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      S_GAP: state_d = S_IDLE;
      S_REQ: begin
        // ack wins over a timeout landing on the same cycle
        if (ack) begin
          d_d     = d_q + WIDTH'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          wait_d  = '0;
          state_d = S_REL;
        end else if (wait_q == TLAST) begin
          terr_d  = 1'b1;
          wait_d  = '0;
          state_d = S_REL;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_REL: if (!ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      wait_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      wait_q  <= wait_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign sync        = (state_q == S_SEND) || (state_q == S_REQ);
  assign q           = sync ? d_q : '0;
  assign busy        = (state_q != S_IDLE);
  assign sent_count  = cnt_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_hs_source.sv
// Directed bench for hs_source: strobe mode at two pulse widths, four-phase mode
// with responder and timeout, reset behaviour and LFSR launch repeatability.
module tb_hs_source;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  en = '0, ak = '0;
  logic [7:0]  q [4];
  logic [15:0] sc [4];
  logic [3:0]  sy, bz, te;

  int checks = 0, errs = 0;

  hs_source #(.MODE(0), .PULSE(1), .THRESH(0)) u0 (.clk(clk), .reset(reset), .enable(en[0]), .ack(ak[0]),
    .q(q[0]), .sync(sy[0]), .busy(bz[0]), .sent_count(sc[0]), .timeout_err(te[0]));
  hs_source #(.MODE(0), .PULSE(3), .THRESH(0)) u1 (.clk(clk), .reset(reset), .enable(en[1]), .ack(ak[1]),
    .q(q[1]), .sync(sy[1]), .busy(bz[1]), .sent_count(sc[1]), .timeout_err(te[1]));
  hs_source #(.MODE(1), .THRESH(0), .TIMEOUT(8)) u2 (.clk(clk), .reset(reset), .enable(en[2]), .ack(ak[2]),
    .q(q[2]), .sync(sy[2]), .busy(bz[2]), .sent_count(sc[2]), .timeout_err(te[2]));
  hs_source u3 (.clk(clk), .reset(reset), .enable(en[3]), .ack(ak[3]),
    .q(q[3]), .sync(sy[3]), .busy(bz[3]), .sent_count(sc[3]), .timeout_err(te[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic wait_sync(input int s, input string tag);
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sy[s]) begin ok = 1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // index of the first cycle >= from at which the reference LFSR allows a launch (default THRESH)
  function automatic int first_launch(input int from);
    logic [15:0] l = 16'hACE1;
    for (int k = 0; k < 2000; k++) begin
      if (k >= from && l[5:0] >= 6'd49) return k;
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    end
    return -1;
  endfunction

  task automatic run_log(output int bad, output int nl, output int log [8]);
    logic prev = 1'b0;
    bad = 0; nl = 0;
    for (int i = 0; i < 8; i++) log[i] = -1;
    en[3] = 1'b0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sy[3] || bz[3]) bad++;
    end
    en[3] = 1'b1;
    for (int i = 100; i < 400; i++) begin
      @(negedge clk);
      if (sy[3] && !prev) begin
        if (nl < 8) log[nl] = i;
        nl++;
      end
      prev = sy[3];
    end
    en[3] = 1'b0;
  endtask

  int cnt, bad1, bad2, nl1, nl2;
  int log1 [8], log2 [8];

  initial begin
    // reset asserted mid-transfer clears outputs before the next edge
    en[0] = 1'b1;
    do_reset();
    wait_sync(0, "rst_wait");
    repeat (3) @(negedge clk);
    chk("rst_pre_sync", 32'(sy[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_q", 32'(q[0]), 32'd0);
    chk("rst_sync", 32'(sy[0]), 32'd0);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    chk("rst_cnt", 32'(sc[0]), 32'd0);
    chk("rst_terr", 32'(te[0]), 32'd0);
    @(negedge clk); reset = 1'b0;

    // strobe, PULSE=1: 3-cycle period, data wraps after 256 transfers
    wait_sync(0, "p1_wait");
    for (int n = 0; n < 260; n++) begin
      chk("p1_sync", 32'(sy[0]), 32'd1);
      chk("p1_q", 32'(q[0]), 32'(n[7:0]));
      chk("p1_busy", 32'(bz[0]), 32'd1);
      @(negedge clk);
      chk("p1_gap_sync", 32'(sy[0]), 32'd0);
      chk("p1_gap_q", 32'(q[0]), 32'd0);
      chk("p1_cnt", 32'(sc[0]), 32'(n + 1));
      @(negedge clk);
      chk("p1_idle_busy", 32'(bz[0]), 32'd0);
      chk("p1_idle_sync", 32'(sy[0]), 32'd0);
      @(negedge clk);
    end
    en[0] = 1'b0;

    // strobe, PULSE=3: each value held 3 cycles, 5-cycle period
    en[1] = 1'b1;
    do_reset();
    wait_sync(1, "p3_wait");
    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < 3; j++) begin
        chk("p3_sync", 32'(sy[1]), 32'd1);
        chk("p3_q", 32'(q[1]), 32'(n));
        @(negedge clk);
      end
      for (int j = 0; j < 2; j++) begin
        chk("p3_low_sync", 32'(sy[1]), 32'd0);
        chk("p3_low_q", 32'(q[1]), 32'd0);
        @(negedge clk);
      end
    end
    en[1] = 1'b0;

    // four-phase with a responder: ack 2 cycles after req, released 1 cycle after req drops
    en[2] = 1'b1; ak[2] = 1'b0;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      wait_sync(2, "hs_wait");
      chk("hs_q", 32'(q[2]), 32'(n));
      chk("hs_cnt_pre", 32'(sc[2]), 32'(n));
      @(negedge clk);
      chk("hs_q_stable", 32'(q[2]), 32'(n));
      chk("hs_sync_hold", 32'(sy[2]), 32'd1);
      ak[2] = 1'b1;
      @(negedge clk);
      chk("hs_rel_sync", 32'(sy[2]), 32'd0);
      chk("hs_rel_q", 32'(q[2]), 32'd0);
      chk("hs_cnt", 32'(sc[2]), 32'(n + 1));
      @(negedge clk);
      chk("hs_rel_hold", 32'(bz[2]), 32'd1);
      ak[2] = 1'b0;
      @(negedge clk);
      chk("hs_idle", 32'(bz[2]), 32'd0);
      chk("hs_terr", 32'(te[2]), 32'd0);
    end

    // four-phase timeout, ack held low: req high exactly 8 cycles, same data re-presented
    for (int t = 0; t < 2; t++) begin
      wait_sync(2, "to_wait");
      chk("to_q", 32'(q[2]), 32'd3);
      cnt = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!sy[2]) break;
        cnt++;
      end
      chk("to_width", 32'(cnt), 32'd8);
      chk("to_terr", 32'(te[2]), 32'd1);
      chk("to_cnt", 32'(sc[2]), 32'd3);
      chk("to_rel", 32'(bz[2]), 32'd1);
      @(negedge clk);
      chk("to_rel_one", 32'(bz[2]), 32'd0);
    end
    en[2] = 1'b0;

    // default THRESH/SEED: idle while disabled, LFSR-paced launches repeat after reset
    run_log(bad1, nl1, log1);
    run_log(bad2, nl2, log2);
    chk("lf_disabled", 32'(bad1), 32'd0);
    chk("lf_disabled2", 32'(bad2), 32'd0);
    chk("lf_any", 32'(nl1 > 0), 32'd1);
    chk("lf_first", 32'(log1[0]), 32'(first_launch(100)));
    for (int j = 0; j < 7; j++)
      if (log1[j] >= 0 && log1[j+1] >= 0)
        chk("lf_next", 32'(log1[j+1]), 32'(first_launch(log1[j] + 3)));
    chk("lf_nl_rep", 32'(nl2), 32'(nl1));
    for (int j = 0; j < 8; j++) chk("lf_rep", 32'(log2[j]), 32'(log1[j]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
